// File: rtl/udp_gmii_tx.sv
// Builds Ethernet/IPv4/UDP frames from a length request and a payload byte stream and
// drives them on the GMII TX interface, including padding, CRC-32 FCS and inter-frame gap.
module udp_gmii_tx #(
    parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_00,
    parameter logic [47:0] DST_MAC    = 48'h11_22_33_44_55_66,
    parameter logic [31:0] SRC_IP     = 32'hC0A8_0132,
    parameter logic [31:0] DST_IP     = 32'hC0A8_0180,
    parameter logic [15:0] SRC_PORT   = 16'hC350,
    parameter logic [15:0] DST_PORT   = 16'hD903,
    parameter logic [7:0]  TTL        = 8'h40,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start_valid,
    output logic        tx_start_ready,
    input  logic [10:0] tx_len,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun,
    output logic        len_err
);
    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_ETH, S_IP, S_UDP, S_PAY, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [10:0] MAX_LEN  = 11'd1472;
    localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES);

    state_t       state, state_nxt;
    logic [10:0]  cnt, cnt_nxt;
    logic [10:0]  len_q;
    logic [10:0]  pad_len;
    logic [15:0]  ip_id;
    logic [15:0]  csum_q;
    logic [31:0]  crc_q;
    logic [15:0]  ip_total;
    logic [15:0]  udp_len;
    logic [31:0]  sum0;
    logic [31:0]  sum1;
    logic [15:0]  csum_nxt;
    logic [335:0] hdr;
    logic [335:0] hdr_sh;
    logic [5:0]   hdr_idx;
    logic [31:0]  crc_inv;
    logic [7:0]   fcs_byte;
    logic [7:0]   txd_nxt;
    logic         en_nxt;
    logic         er_nxt;
    logic         len_ok;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    assign len_ok         = (tx_len != 11'd0) && (tx_len <= MAX_LEN);
    assign tx_start_ready = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign ip_total       = {5'd0, len_q} + 16'd28;
    assign udp_len        = {5'd0, len_q} + 16'd8;
    assign pad_len        = (len_q < 11'd18) ? (11'd18 - len_q) : 11'd0;

    // Checksum depends only on length and ID, so it settles during the preamble.
    assign sum0 = 32'h0000_4500 + {16'h0, ip_total} + {16'h0, ip_id} + {16'h0, TTL, 8'h11}
                + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
                + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};
    assign sum1     = {16'h0, sum0[15:0]} + {16'h0, sum0[31:16]};
    assign csum_nxt = ~(sum1[15:0] + sum1[31:16]);

    assign hdr = {DST_MAC, SRC_MAC, 16'h0800,
                  16'h4500, ip_total, ip_id, 16'h0000, TTL, 8'h11, csum_q, SRC_IP, DST_IP,
                  SRC_PORT, DST_PORT, udp_len, 16'h0000};
    assign hdr_idx = (state == S_IP)  ? cnt[5:0] + 6'd14 :
                     (state == S_UDP) ? cnt[5:0] + 6'd34 : cnt[5:0];
    assign hdr_sh  = hdr << {hdr_idx, 3'b000};
    assign crc_inv = ~crc_q;

    always_comb begin
        case (cnt[1:0])
            2'd0:    fcs_byte = crc_inv[7:0];
            2'd1:    fcs_byte = crc_inv[15:8];
            2'd2:    fcs_byte = crc_inv[23:16];
            default: fcs_byte = crc_inv[31:24];
        endcase
    end

    // Everything here describes the byte registered onto GMII at the next edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 11'd1;
        txd_nxt   = 8'h00;
        en_nxt    = 1'b0;
        er_nxt    = 1'b0;
        s_tready  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = 11'd0;
                if (tx_start_valid && len_ok) begin
                    state_nxt = S_PRE;
                    cnt_nxt   = 11'd1;
                    txd_nxt   = 8'h55;
                    en_nxt    = 1'b1;
                end
            end
            S_PRE: begin
                en_nxt  = 1'b1;
                txd_nxt = (cnt == 11'd7) ? 8'hD5 : 8'h55;
                if (cnt == 11'd7) begin
                    state_nxt = S_ETH;
                    cnt_nxt   = 11'd0;
                end
            end
            S_ETH, S_IP, S_UDP: begin
                en_nxt  = 1'b1;
                txd_nxt = hdr_sh[335:328];
                if (state == S_ETH && cnt == 11'd13) begin
                    state_nxt = S_IP;
                    cnt_nxt   = 11'd0;
                end else if (state == S_IP && cnt == 11'd19) begin
                    state_nxt = S_UDP;
                    cnt_nxt   = 11'd0;
                end else if (state == S_UDP && cnt == 11'd7) begin
                    state_nxt = S_PAY;
                    cnt_nxt   = 11'd0;
                end
            end
            S_PAY: begin
                en_nxt   = 1'b1;
                s_tready = s_tvalid;
                txd_nxt  = s_tvalid ? s_tdata : 8'h00;
                er_nxt   = ~s_tvalid;
                if (cnt == len_q - 11'd1) begin
                    state_nxt = (pad_len != 11'd0) ? S_PAD : S_FCS;
                    cnt_nxt   = 11'd0;
                end
            end
            S_PAD: begin
                en_nxt = 1'b1;
                if (cnt == pad_len - 11'd1) begin
                    state_nxt = S_FCS;
                    cnt_nxt   = 11'd0;
                end
            end
            S_FCS: begin
                en_nxt  = 1'b1;
                txd_nxt = fcs_byte;
                if (cnt == 11'd3) begin
                    state_nxt = S_IFG;
                    cnt_nxt   = 11'd0;
                end
            end
            S_IFG: begin
                if (cnt == IFG_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 11'd0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 11'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 11'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: every register here is reset, so an aborted frame leaves nothing behind to resume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            gmii_tx_er <= 1'b0;
            underrun   <= 1'b0;
            len_err    <= 1'b0;
            frame_done <= 1'b0;
            len_q      <= 11'd0;
            ip_id      <= 16'h0000;
            csum_q     <= 16'h0000;
            crc_q      <= 32'hFFFF_FFFF;
        end else begin
            gmii_txd   <= txd_nxt;
            gmii_tx_en <= en_nxt;
            gmii_tx_er <= er_nxt;
            underrun   <= (state == S_PAY) && !s_tvalid;
            len_err    <= (state == S_IDLE) && tx_start_valid && !len_ok;
            frame_done <= (state == S_IFG) && (cnt == 11'd0);
            if ((state == S_IDLE) && tx_start_valid && len_ok)
                len_q <= tx_len;
            if (state == S_PRE) begin
                csum_q <= csum_nxt;
                crc_q  <= 32'hFFFF_FFFF;
            end
            if (state inside {S_ETH, S_IP, S_UDP, S_PAY, S_PAD})
                crc_q <= crc_byte(crc_q, txd_nxt);
            if ((state == S_IFG) && (cnt == 11'd0))
                ip_id <= ip_id + 16'd1;
        end
    end
endmodule

// File: tb/tb_udp_gmii_tx.sv
// Randomized self-checking bench for udp_gmii_tx: a frame-level reference model fills an
// expected byte queue that a monitor compares against GMII on every cycle.
module tb_udp_gmii_tx;
    localparam logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_00;
    localparam logic [47:0] DST_MAC  = 48'h11_22_33_44_55_66;
    localparam logic [31:0] SRC_IP   = 32'hC0A8_0132;
    localparam logic [31:0] DST_IP   = 32'hC0A8_0180;
    localparam logic [15:0] SRC_PORT = 16'hC350;
    localparam logic [15:0] DST_PORT = 16'hD903;
    localparam logic [7:0]  TTL      = 8'h40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_start_valid = 1'b0;
    logic        tx_start_ready;
    logic [10:0] tx_len = 11'd0;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic        frame_done;
    logic        underrun;
    logic        len_err;

    udp_gmii_tx dut (
        .clk(clk), .rst_n(rst_n),
        .tx_start_valid(tx_start_valid), .tx_start_ready(tx_start_ready), .tx_len(tx_len),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .busy(busy), .frame_done(frame_done), .underrun(underrun), .len_err(len_err)
    );

    always #4 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  pay [0:1471];
    logic        vld [0:1471];
    logic [7:0]  bq[$];
    logic        bq_er[$];
    logic [8:0]  exp_q[$];
    int          exp_len_q[$];
    logic [15:0] model_id = 16'h0000;

    function automatic logic [15:0] ip_csum(input int len, input logic [15:0] id);
        logic [15:0] w [10];
        int s;
        w = '{16'h4500, 16'(28 + len), id, 16'h0000, {TTL, 8'h11}, 16'h0000,
              SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0]};
        s = 0;
        foreach (w[i]) s += int'(w[i]);
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return ~16'(s);
    endfunction

    function automatic logic [31:0] crc32(input logic [7:0] d[$]);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFF_FFFF;
        foreach (d[i])
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[i][b];
                c = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        return ~c;
    endfunction

    function automatic void put(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bq.push_back(v[8*i +: 8]);
            bq_er.push_back(1'b0);
        end
    endfunction

    function automatic void push_frame(input int len, input logic [15:0] id);
        logic [31:0] fcs;
        bq.delete();
        bq_er.delete();
        put(DST_MAC, 6); put(SRC_MAC, 6); put(48'h0800, 2);
        put(48'h4500, 2); put(48'(28 + len), 2); put({32'h0, id}, 2); put(48'h0, 2);
        put({40'h0, TTL}, 1); put(48'h11, 1); put({32'h0, ip_csum(len, id)}, 2);
        put({16'h0, SRC_IP}, 4); put({16'h0, DST_IP}, 4);
        put({32'h0, SRC_PORT}, 2); put({32'h0, DST_PORT}, 2); put(48'(8 + len), 2); put(48'h0, 2);
        for (int k = 0; k < len; k++) begin
            bq.push_back(vld[k] ? pay[k] : 8'h00);
            bq_er.push_back(!vld[k]);
        end
        while (bq.size() < 60) begin
            bq.push_back(8'h00);
            bq_er.push_back(1'b0);
        end
        fcs = crc32(bq);
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        foreach (bq[i]) exp_q.push_back({bq_er[i], bq[i]});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, fcs[8*i +: 8]});
        exp_len_q.push_back(8 + ((42 + len) > 60 ? 42 + len : 60) + 4);
    endfunction

    // ---------------- monitor / compare ----------------
    logic [7:0] cap [0:1599];
    logic [8:0] e;
    int cap_n = 0, en_run = 0, last_run = 0, fall_cyc = 0, el;
    int n_frames = 0, n_done = 0, n_under = 0, n_lerr = 0, n_er = 0;
    bit prev_en = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_len_q.delete();
            en_run = 0;
            prev_en = 1'b0;
        end else begin
            if (frame_done) n_done++;
            if (underrun) n_under++;
            if (len_err) n_lerr++;
            if (gmii_tx_er) n_er++;
            check("ready_vs_busy", tx_start_ready, !busy);
            if (gmii_tx_en) begin
                if (en_run == 0) cap_n = 0;
                if (exp_q.size() == 0) check("unexpected_tx_en", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("txd", gmii_txd, e[7:0]);
                    check("tx_er", gmii_tx_er, e[8]);
                    check("underrun_flag", underrun, e[8]);
                end
                if (cap_n < 1600) begin
                    cap[cap_n] = gmii_txd;
                    cap_n++;
                end
                en_run++;
            end else begin
                check("idle_txd", gmii_txd, 0);
                check("idle_er", gmii_tx_er, 0);
                check("idle_underrun", underrun, 0);
                check("frame_done_timing", frame_done, prev_en);
                if (prev_en) begin
                    fall_cyc = cyc;
                    last_run = en_run;
                    if (exp_len_q.size() == 0) check("frame_len_unexpected", 1, 0);
                    else begin
                        el = exp_len_q.pop_front();
                        check("frame_len", en_run, el);
                    end
                    n_frames++;
                end
                en_run = 0;
            end
            prev_en = gmii_tx_en;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input int len, output int acc_cyc);
        int n;
        n = 0;
        tx_start_valid = 1'b1;
        tx_len = 11'(len);
        while (!tx_start_ready && n < 3000) begin
            tick();
            n++;
        end
        check("accept_timeout", tx_start_ready, 1);
        acc_cyc = cyc;
        push_frame(len, model_id);
        model_id++;
        tick();
        tx_start_valid = 1'b0;
    endtask

    task automatic drive_payload(input int len);
        for (int i = 0; i < 49; i++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            s_tdata = 8'($urandom);
            #1;
            check("s_tready_outside", s_tready, 0);
            tick();
        end
        for (int k = 0; k < len; k++) begin
            s_tvalid = vld[k];
            s_tdata = pay[k];
            #1;
            check("s_tready_payload", s_tready, vld[k]);
            tick();
        end
        s_tvalid = 1'b0;
        s_tdata = 8'h00;
        #1;
        check("s_tready_after", s_tready, 0);
    endtask

    task automatic wait_end(input int f0);
        int n;
        n = 0;
        while (n_frames == f0 && n < 4000) begin
            tick();
            n++;
        end
        check("frame_end_timeout", n_frames > f0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((!tx_start_ready || exp_q.size() != 0) && n < 4000) begin
            tick();
            n++;
        end
        check("idle_timeout", tx_start_ready, 1);
    endtask

    task automatic check_fcs(input string name);
        logic [7:0] q[$];
        logic [31:0] f;
        for (int i = 8; i < last_run - 4; i++) q.push_back(cap[i]);
        f = crc32(q);
        check(name, {cap[last_run-1], cap[last_run-2], cap[last_run-3], cap[last_run-4]}, f);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, f0, u0, d0, er0, l0, len, starved;
        logic [7:0] q[$];
        logic [7:0] t10 [8];

        // Reset state and model pins
        repeat (3) tick();
        check("rst_txd", gmii_txd, 0);
        check("rst_en", gmii_tx_en, 0);
        check("rst_er", gmii_tx_er, 0);
        check("rst_ready", tx_start_ready, 1);
        check("rst_s_tready", s_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {frame_done, underrun, len_err}, 0);
        rst_n = 1'b1;
        tick();
        check("model_csum_id0", ip_csum(8, 16'h0000), 16'hF6C6);
        check("model_csum_id1", ip_csum(8, 16'h0001), 16'hF6C5);
        for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
        check("model_crc_check", crc32(q), 32'hCBF4_3926);

        // len=8 known payload, followed by a back-to-back second frame
        t10 = '{8'h10, 8'h20, 8'h01, 8'h00, 8'h64, 8'hC0, 8'h0A, 8'h00};
        for (int k = 0; k < 8; k++) begin pay[k] = t10[k]; vld[k] = 1'b1; end
        f0 = n_frames; d0 = n_done;
        request(8, acc);
        drive_payload(8);
        wait_end(f0);
        check("t1_run", last_run, 72);
        check("t1_total_len", {cap[24], cap[25]}, 16'h0024);
        check("t1_ip_id", {cap[26], cap[27]}, 16'h0000);
        check("t1_csum", {cap[32], cap[33]}, 16'hF6C6);
        check("t1_udp_len", {cap[46], cap[47]}, 16'h0010);
        for (int i = 58; i < 68; i++) check("t1_pad", cap[i], 8'h00);
        check_fcs("t1_fcs");
        check("t1_done_once", n_done - d0, 1);
        tx_start_valid = 1'b1;
        tick();
        f0 = n_frames;
        for (int k = 0; k < 8; k++) pay[k] = 8'($urandom);
        request(8, acc2);
        check("t2_ifg_gap", acc2 - fall_cyc, 12);
        drive_payload(8);
        wait_end(f0);
        check("t2_ip_id", {cap[26], cap[27]}, 16'h0001);
        check("t2_csum", {cap[32], cap[33]}, 16'hF6C5);
        wait_idle();

        // Maximum length, incrementing payload
        for (int k = 0; k < 1472; k++) begin pay[k] = 8'(k); vld[k] = 1'b1; end
        f0 = n_frames;
        request(1472, acc);
        drive_payload(1472);
        wait_end(f0);
        check("t3_run", last_run, 8 + 1514 + 4);
        check("t3_total_len", {cap[24], cap[25]}, 16'h05DC);
        check_fcs("t3_fcs");
        wait_idle();

        // Starved payload byte 2 in a len=4 frame
        for (int k = 0; k < 4; k++) begin pay[k] = 8'($urandom_range(1, 255)); vld[k] = (k != 2); end
        f0 = n_frames; u0 = n_under; er0 = n_er;
        request(4, acc);
        drive_payload(4);
        wait_end(f0);
        check("t4_run", last_run, 72);
        check("t4_starved_byte", cap[52], 8'h00);
        check("t4_underrun_count", n_under - u0, 1);
        check("t4_er_count", n_er - er0, 1);
        wait_idle();

        // Illegal lengths
        l0 = n_lerr;
        foreach (t10[i]) t10[i] = 8'h00;
        for (int j = 0; j < 2; j++) begin
            tx_len = (j == 0) ? 11'd0 : 11'd1473;
            tx_start_valid = 1'b1;
            tick();
            tx_start_valid = 1'b0;
            check("t5_len_err_pulse", len_err, 1);
            check("t5_ready", tx_start_ready, 1);
            tick();
            check("t5_len_err_clear", len_err, 0);
        end
        repeat (10) tick();
        check("t5_no_tx", gmii_tx_en, 0);
        check("t5_still_ready", tx_start_ready, 1);
        check("t5_len_err_count", n_lerr - l0, 2);

        // Reset during the UDP header
        for (int k = 0; k < 8; k++) begin pay[k] = 8'($urandom); vld[k] = 1'b1; end
        request(8, acc);
        repeat (43) tick();
        check("t6_mid_frame_en", gmii_tx_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_en", gmii_tx_en, 0);
        check("t6_rst_txd", gmii_txd, 0);
        check("t6_rst_ready", tx_start_ready, 1);
        check("t6_rst_busy", busy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        model_id = 16'h0000;
        tick();
        f0 = n_frames;
        request(8, acc);
        drive_payload(8);
        wait_end(f0);
        check("t6_ip_id_after_reset", {cap[26], cap[27]}, 16'h0000);
        check("t6_run", last_run, 72);
        wait_idle();

        // Randomized frames around the padding boundary
        for (int r = 0; r < 8; r++) begin
            len = (r < 4) ? 16 + r : $urandom_range(1, 80);
            starved = 0;
            for (int k = 0; k < len; k++) begin
                pay[k] = 8'($urandom);
                vld[k] = ($urandom_range(0, 7) != 0);
                if (!vld[k]) starved++;
            end
            f0 = n_frames; u0 = n_under;
            request(len, acc);
            drive_payload(len);
            wait_end(f0);
            check("rand_underruns", n_under - u0, starved);
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/udp_gmii_tx.md
# udp_gmii_tx

Builds and transmits complete Ethernet/IPv4/UDP frames on the GMII TX byte interface in the 125 MHz domain, the transmit counterpart of the GMII RX/UDP extraction path. A client gives a payload length, then streams exactly that many payload bytes. The block emits, in order: preamble/SFD, the Ethernet header, the IPv4 header with a computed header checksum, the UDP header, the payload, zero padding to the Ethernet minimum, the CRC-32 FCS, and the inter-frame gap. It feeds the PHY-side `gmii_txd`/`gmii_tx_en`.

## Interface
Parameters:
- `SRC_MAC`, default 48'h02_00_00_00_00_00: FPGA MAC, Ethernet source.
- `DST_MAC`, default 48'h11_22_33_44_55_66: host MAC, Ethernet destination.
- `SRC_IP`, default 32'hC0A8_0132: 192.168.1.50.
- `DST_IP`, default 32'hC0A8_0180: 192.168.1.128.
- `SRC_PORT`, default 16'hC350: 50000.
- `DST_PORT`, default 16'hD903: 55555.
- `TTL`, default 8'h40: IP TTL.
- `IFG_CYCLES`, default 12: idle cycles after the FCS.

Ports:
- `clk` in 1: 125 MHz GMII TX clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tx_start_valid` in 1: frame request.
- `tx_start_ready` out 1: high only in IDLE.
- `tx_len` in 11: UDP payload bytes. Legal range 1..1472.
- `s_tdata` in 8: payload byte.
- `s_tvalid` in 1: payload byte valid.
- `s_tready` out 1: payload byte consumed this cycle.
- `gmii_txd` out 8: GMII data.
- `gmii_tx_en` out 1: GMII enable.
- `gmii_tx_er` out 1: GMII error.
- `busy` out 1: not IDLE.
- `frame_done` out 1: 1-cycle pulse after the last FCS byte.
- `underrun` out 1: 1-cycle pulse per starved payload byte.
- `len_err` out 1: 1-cycle pulse on a rejected request.

## Operation
- States: IDLE → PREAMBLE(8) → ETH(14) → IP(20) → UDP(8) → PAYLOAD(len) → PAD(max(0,18−len)) → FCS(4) → IFG(IFG_CYCLES) → IDLE. A byte counter sequences bytes within each state.
- Request handshake:
  - Accept on `tx_start_valid && tx_start_ready`. `tx_len` is latched at accept.
  - If `tx_len`==0 or `tx_len`>1472: no frame is sent, `len_err` pulses the next cycle, and the block stays in IDLE.
- PREAMBLE: 7×0x55, then 0xD5.
- ETH: DST_MAC, SRC_MAC, then 0x08 0x00. All fields MSB byte first.
- IP header fields:
  - 0x45, 0x00
  - Total length = 28+len
  - Identification = 16-bit frame counter. Reset 0; increments after each sent frame; wraps at 0xFFFF→0.
  - Flags/fragment 0x0000
  - TTL, 0x11
  - Header checksum
  - SRC_IP, DST_IP
- IP header checksum:
  - One's-complement of the 16-bit one's-complement sum of the ten header words, with the checksum word taken as 0.
  - Carries are folded twice.
  - Must be ready before IP byte 10. The 8 PREAMBLE cycles are available for computing it.
- UDP header: SRC_PORT, DST_PORT, length = 8+len, checksum 0x0000.
- PAYLOAD:
  - `s_tready`=1 in each PAYLOAD cycle where `s_tvalid`=1. That byte appears on `gmii_txd` the next cycle.
  - If `s_tvalid`=0 in a PAYLOAD cycle: the block emits 0x00 with `gmii_tx_er`=1 for that byte, pulses `underrun`, and still counts the byte. The frame length never changes.
  - `s_tready` is 0 outside PAYLOAD.
- PAD: 0x00 bytes, so that destination MAC through pad totals ≥60 bytes.
- FCS (CRC-32):
  - Polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, final inversion.
  - Covers destination MAC through the last pad byte.
  - Transmitted as the four bytes of the complemented reflected CRC, least-significant byte first.
- IFG: `gmii_tx_en`=0 and `gmii_txd`=0. `frame_done` pulses in the first IFG cycle.

## Timing
- All GMII outputs are registered.
- The first 0x55 appears on `gmii_txd` the cycle after accept.
- `gmii_tx_en` is high for exactly 8+max(60, 42+len)+4 consecutive cycles, with no gaps.
- The next `tx_start_ready` comes IFG_CYCLES cycles after `gmii_tx_en` falls.
- Reset values:
  - `gmii_txd`=0, `gmii_tx_en`=0, `gmii_tx_er`=0
  - `tx_start_ready`=1, `s_tready`=0, `busy`=0
  - Pulses 0, ID counter 0, state IDLE
- Reset mid-frame: all outputs drop to their reset values immediately (asynchronously). No truncated frame resumes after reset.
- `tx_start_valid` while busy is ignored and not queued.

## Test plan
- len=8, payload 10 20 01 00 64 C0 0A 00, `s_tvalid` held high:
  - 72 tx_en cycles
  - IP total length 0x0024, IP ID 0x0000, checksum 0xF6C6
  - UDP length 0x0010
  - 10 pad bytes
  - FCS equals a bench CRC-32 model
  - `frame_done` pulses once
- Two back-to-back requests:
  - Second accepted exactly 12 idle cycles after the first tx_en falls.
  - IP ID 0x0001 on the second frame; its checksum recomputed as 0xF6C5.
- len=1472, payload incrementing:
  - 8+1514+4 tx_en cycles, no pad
  - IP total length 0x05DC
  - FCS matches the model
- len=4 with `s_tvalid` low for payload byte 2:
  - That byte is 0x00 with `gmii_tx_er`=1
  - One `underrun` pulse
  - Frame length unchanged at 72 tx_en cycles
- len=0 and then len=1473:
  - `len_err` pulses for each
  - `gmii_tx_en` stays 0
  - `tx_start_ready` stays 1
- `rst_n` low during UDP header bytes:
  - `gmii_tx_en`=0 immediately
  - After release, the next frame starts cleanly with IP ID 0x0000
